// File: rtl/obi_resp_pkg.sv
// Shared types for the OBI heap-SRAM responder.
// Words are 33 bits wide; bit 32 carries the CHERI tag.
package obi_resp_pkg;

  localparam int OBI_WORD_W = 33;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } gnt_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [OBI_WORD_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response shift register.
// Only the valid bits are reset; payload flows freely.
module obi_resp_pipe
  import obi_resp_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  input  obi_resp_t in_i,
  output obi_resp_t out_o
);

  logic [Depth-1:0]    vld_q;
  logic [Depth-1:0]    vld_d;
  logic [OBI_WORD_W:0] pay_q [Depth];
  logic [OBI_WORD_W:0] pay_d [Depth];

  always_comb begin
    vld_d    = vld_q;
    pay_d    = pay_q;
    vld_d[0] = in_i.valid;
    pay_d[0] = {in_i.err, in_i.rdata};
    for (int i = 1; i < Depth; i++) begin
      vld_d[i] = vld_q[i-1];
      pay_d[i] = pay_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pay_q <= pay_d;
  end

  assign out_o = {vld_q[Depth-1], pay_q[Depth-1]};

endmodule

// File: rtl/obi_mem_responder.sv
// OBI heap-SRAM target: stalled grant, fixed-latency response.
// Define OBI_RESP_TAG_STRIP_EN to clear the tag on partial writes.
module obi_mem_responder
  import obi_resp_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h2000_0000,
  parameter int          MemDepth    = 1024,
  parameter int          GntStall    = 0,
  parameter int          RespLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [OBI_WORD_W-1:0] wdata_i,
  output logic [OBI_WORD_W-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o
);

  localparam int SW = (GntStall > 0) ? $clog2(GntStall + 1) : 1;
  localparam int IW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  gnt_state_t    state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          gnt_raw;
  logic          gnt;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    gnt_raw = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (GntStall == 0) begin
            gnt_raw = 1'b1;
          end else begin
            state_d = ST_STALL;
            stall_d = SW'(1);
          end
        end
      end
      ST_STALL: begin
        if (!req_i) begin
          state_d = ST_IDLE;
          stall_d = '0;
        end else if (stall_q == SW'(GntStall)) begin
          gnt_raw = 1'b1;
          state_d = ST_IDLE;
          stall_d = '0;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Suppress grants (and hence memory writes) while reset is held.
  assign gnt   = gnt_raw & rstn_i;
  assign gnt_o = gnt;

  logic [31:0]   off;
  logic [IW-1:0] idx;
  logic          ok;
  logic          wr_en;
  logic          tag_wr;

  assign off = addr_i - BaseAddr;
  assign idx = off[IW+1:2];
  assign ok  = (addr_i >= BaseAddr) &&
               ({2'b00, off[31:2]} < 32'(MemDepth)) &&
               (addr_i[1:0] == 2'b00);
  assign wr_en = gnt & ok & we_i;

`ifdef OBI_RESP_TAG_STRIP_EN
  assign tag_wr = (be_i == 4'hf) ? wdata_i[32] : 1'b0;
`else
  assign tag_wr = wdata_i[32];
`endif

  logic [31:0]         mem_q [MemDepth];
  logic [MemDepth-1:0] tag_q, tag_d;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    tag_d = tag_q;
    if (wr_en) begin
      tag_d[idx] = tag_wr;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  obi_resp_t resp_in;
  obi_resp_t resp_out;

  always_comb begin
    resp_in       = '0;
    resp_in.valid = gnt;
    resp_in.err   = ~ok;
    if (ok && !we_i) begin
      resp_in.rdata = {tag_q[idx], mem_q[idx]};
    end
  end

  obi_resp_pipe #(
    .Depth(RespLatency)
  ) u_pipe (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .in_i  (resp_in),
    .out_o (resp_out)
  );

  assign rvalid_o = resp_out.valid;
  assign err_o    = resp_out.valid & resp_out.err;
  assign rdata_o  = resp_out.valid ? resp_out.rdata : '0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Randomized bench for obi_mem_responder, three stall/latency configs,
// checked against a cycle-calendar model of the memory and grant rules.
module tb_obi_mem_responder;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 1024;
  localparam int          NK    = 3;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        req    [NK];
  logic        we     [NK];
  logic [31:0] addr   [NK];
  logic [3:0]  be     [NK];
  logic [32:0] wdata  [NK];
  logic        gnt    [NK];
  logic        rvalid [NK];
  logic        err    [NK];
  logic [32:0] rdata  [NK];

  always #5 clk = ~clk;

  obi_mem_responder #(
    .BaseAddr(BASE), .MemDepth(DEPTH), .GntStall(0), .RespLatency(1)
  ) dut0 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .rdata_o(rdata[0]), .rvalid_o(rvalid[0]), .err_o(err[0])
  );

  obi_mem_responder #(
    .BaseAddr(BASE), .MemDepth(DEPTH), .GntStall(2), .RespLatency(2)
  ) dut1 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .rdata_o(rdata[1]), .rvalid_o(rvalid[1]), .err_o(err[1])
  );

  obi_mem_responder #(
    .BaseAddr(BASE), .MemDepth(DEPTH), .GntStall(0), .RespLatency(3)
  ) dut2 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[2]), .gnt_o(gnt[2]),
    .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]),
    .rdata_o(rdata[2]), .rvalid_o(rvalid[2]), .err_o(err[2])
  );

  function automatic int gs(int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int rl(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 3);
  endfunction

  logic [32:0] shadow  [NK][DEPTH];
  int          run_len [NK];
  bit          sched_v [NK][8];
  bit          sched_e [NK][8];
  logic [32:0] sched_d [NK][8];
  bit          gnt_seen  [NK];
  logic [32:0] last_exp_d[NK];
  bit          last_exp_e[NK];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: grant on the (GntStall+1)th consecutive req cycle; response
  // is booked into a calendar slot RespLatency cycles after the grant.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NK; k++) begin
      bit          eg;
      bit          ok;
      int          slot;
      int          idx;
      logic [31:0] off;
      logic [32:0] d;
      eg   = 1'b0;
      slot = cyc % 8;
      if (!rstn) begin
        run_len[k] = 0;
        for (int s = 0; s < 8; s++) sched_v[k][s] = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[k][i][32] = 1'b0;
      end else begin
        if (req[k]) run_len[k]++;
        else run_len[k] = 0;
        if (req[k] && run_len[k] == gs(k) + 1) begin
          eg         = 1'b1;
          run_len[k] = 0;
          off = addr[k] - BASE;
          ok  = (addr[k] >= BASE) && ((off >> 2) < DEPTH) &&
                (addr[k][1:0] == 2'b00);
          idx = int'(off >> 2);
          d   = '0;
          if (ok && we[k]) begin
            for (int b = 0; b < 4; b++)
              if (be[k][b]) shadow[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
`ifdef OBI_RESP_TAG_STRIP_EN
            shadow[k][idx][32] = (be[k] == 4'hf) ? wdata[k][32] : 1'b0;
`else
            shadow[k][idx][32] = wdata[k][32];
`endif
          end else if (ok) begin
            d = shadow[k][idx];
          end
          sched_v[k][(cyc + rl(k)) % 8] = 1'b1;
          sched_e[k][(cyc + rl(k)) % 8] = ~ok;
          sched_d[k][(cyc + rl(k)) % 8] = d;
          last_exp_d[k] = d;
          last_exp_e[k] = ~ok;
        end
      end
      gnt_seen[k] = eg;
      chk($sformatf("gnt%0d", k), 64'(gnt[k]), 64'(eg));
      chk($sformatf("rvalid%0d", k), 64'(rvalid[k]), 64'(sched_v[k][slot]));
      chk($sformatf("err%0d", k), 64'(err[k]),
          64'(sched_v[k][slot] & sched_e[k][slot]));
      chk($sformatf("rdata%0d", k), 64'(rdata[k]),
          sched_v[k][slot] ? 64'(sched_d[k][slot]) : 64'd0);
      sched_v[k][slot] = 1'b0;
    end
  end

  task automatic issue(input int k, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [32:0] wd,
                       output int waited);
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    be[k]    = b;
    wdata[k] = wd;
    waited   = 0;
    do begin
      @(posedge clk);
      waited++;
    end while (!gnt_seen[k] && waited < 20);
    if (!gnt_seen[k]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout k=%0d: got none expected grant", k);
    end
    #1;
    req[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int          w;
  int          cnt;
  logic [31:0] a;
  logic [32:0] exp_pw;

  initial begin
    for (int k = 0; k < NK; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
      be[k] = '0; wdata[k] = '0;
    end
    idle(3);
    rstn = 1'b1;
    idle(2);

    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 32; i++)
        issue(k, 1'b1, BASE + 32'(4 * i), 4'hf,
              {1'($urandom), 32'($urandom)}, w);
    idle(4);

    issue(0, 1'b1, 32'h2000_0010, 4'hf, 33'h1_DEAD_BEEF, w);
    chk("same_cycle_gnt", 64'(w), 64'd1);
    issue(0, 1'b0, 32'h2000_0010, 4'h0, 33'h0, w);
    chk("raw_data", 64'(last_exp_d[0]), 64'(33'h1_DEAD_BEEF));
    chk("raw_err", 64'(last_exp_e[0]), 64'd0);
    idle(3);

    req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE;
    idle(1);
    req[1] = 1'b0;
    idle(2);
    issue(1, 1'b0, 32'h2000_0010, 4'h0, 33'h0, w);
    chk("stall_gnt_cycles", 64'(w), 64'd3);
    idle(3);

    for (int k = 0; k < NK; k++) begin
      issue(k, 1'b0, 32'h1FFF_FFFC, 4'hf, 33'h0, w);
      chk("err_below", 64'({last_exp_e[k], last_exp_d[k]}), 64'(34'h2_0000_0000));
      issue(k, 1'b0, 32'h2000_1000, 4'hf, 33'h0, w);
      chk("err_above", 64'({last_exp_e[k], last_exp_d[k]}), 64'(34'h2_0000_0000));
      issue(k, 1'b0, 32'h2000_0002, 4'hf, 33'h0, w);
      chk("err_misalign", 64'({last_exp_e[k], last_exp_d[k]}), 64'(34'h2_0000_0000));
    end
    idle(4);

`ifdef OBI_RESP_TAG_STRIP_EN
    exp_pw = 33'h0_AAAA_5678;
`else
    exp_pw = 33'h1_AAAA_5678;
`endif
    for (int k = 0; k < NK; k++) begin
      issue(k, 1'b1, BASE + 32'h14, 4'hf, 33'h1_AAAA_AAAA, w);
      issue(k, 1'b1, BASE + 32'h14, 4'b0011, 33'h1_1234_5678, w);
      issue(k, 1'b0, BASE + 32'h14, 4'h0, 33'h0, w);
      chk("partial_write", 64'(last_exp_d[k]), 64'(exp_pw));
    end
    idle(4);

    issue(2, 1'b0, BASE + 32'h0, 4'h0, 33'h0, w);
    issue(2, 1'b0, BASE + 32'h4, 4'h0, 33'h0, w);
    issue(2, 1'b0, BASE + 32'h8, 4'h0, 33'h0, w);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[2]) cnt++;
    end
    chk("b2b_rvalid_count", 64'(cnt), 64'd3);
    idle(2);

    issue(2, 1'b1, BASE + 32'h1c, 4'hf, 33'h1_CAFE_F00D, w);
    issue(2, 1'b0, BASE + 32'h1c, 4'h0, 33'h0, w);
    issue(2, 1'b0, BASE + 32'h20, 4'h0, 33'h0, w);
    #2;
    rstn = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rvalid[2]) cnt++;
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rvalid[2]) cnt++;
    end
    chk("rvalid_after_reset", 64'(cnt), 64'd0);
    idle(1);
    issue(2, 1'b0, BASE + 32'h1c, 4'h0, 33'h0, w);
    chk("tag_cleared", 64'(last_exp_d[2]), 64'(33'h0_CAFE_F00D));
    idle(4);

    for (int n = 0; n < 500; n++) begin
      int k;
      int r;
      k = $urandom_range(0, NK - 1);
      r = $urandom_range(0, 9);
      if (r < 8) begin
        a = BASE + 32'(4 * $urandom_range(0, 31));
      end else begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'd4;
          1: a = BASE + 32'(4 * DEPTH);
          2: a = BASE + 32'(4 * $urandom_range(0, 31) + 1);
          default: a = 32'h0000_0000;
        endcase
      end
      issue(k, 1'($urandom), a, 4'($urandom),
            {1'($urandom), 32'($urandom)}, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
